id_decoder: RTL and testbench

Instruction-decode stage of the fetch/decode/execute pipeline. It takes the 64-bit IF/ID pipeline word (PC plus instruction) and splits out the register fields. It builds the immediate, branch target and jump target, and decodes a MIPS-style subset into control signals. The result is registered into the 192-bit ID/EX pipeline word once per clock.

---
 rtl/id_decoder.sv | 186 ++++++++++++++++++
 tb/tb_id_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/id_decoder.sv
// Instruction-decode stage: splits the IF/ID word into fields, immediates, targets and
// control flags, and registers the result into the 192-bit ID/EX word.
module id_decoder (
  input  logic         clock,
  input  logic         reset,
  input  logic [63:0]  IF_ID,
  output logic [191:0] ID_EX
);

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
    sext16 = {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    zext16 = {{(DATA_W-16){1'b0}}, v};
  endfunction

  logic [31:0] pc;
  logic [31:0] ins;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  assign pc    = IF_ID[63:32];
  assign ins   = IF_ID[31:0];
  assign op    = ins[31:26];
  assign rs    = ins[25:21];
  assign rt    = ins[20:16];
  assign rd    = ins[15:11];
  assign funct = ins[5:0];

  logic signed [DATA_W-1:0] imm_s;
  logic        [DATA_W-1:0] br_off;
  logic        [DATA_W-1:0] imm;
  logic        [DATA_W-1:0] br_tgt;
  logic        [DATA_W-1:0] j_tgt;

  assign imm_s  = sext16(ins[15:0]);
  assign br_off = imm_s <<< 2;
  assign br_tgt = pc + br_off;
  assign j_tgt  = {pc[31:28], ins[25:0], 2'b00};
  assign imm    = (op == OP_ANDI || op == OP_ORI) ? zext16(ins[15:0]) : imm_s;

  logic [3:0] alu_ctrl;
  logic [4:0] dest;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       alu_src_imm;
  logic       branch;
  logic       jump;
  logic       illegal;

  always_comb begin
    alu_ctrl    = ALU_AND;
    dest        = 5'd0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    illegal     = 1'b0;

    unique case (op)
      OP_RTYPE: begin
        reg_write = 1'b1;
        dest      = rd;
        unique case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_NOR:  alu_ctrl = ALU_NOR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_SLL:  alu_ctrl = ALU_SLL;
          default: illegal  = 1'b1;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        dest        = rt;
        unique case (op)
          OP_ADDI: alu_ctrl = ALU_ADD;
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_SLT;
        endcase
      end
      OP_LW: begin
        alu_ctrl    = ALU_ADD;
        reg_write   = 1'b1;
        mem_read    = 1'b1;
        mem_to_reg  = 1'b1;
        alu_src_imm = 1'b1;
        dest        = rt;
      end
      OP_SW: begin
        alu_ctrl    = ALU_ADD;
        mem_write   = 1'b1;
        alu_src_imm = 1'b1;
      end
      OP_BEQ: begin
        alu_ctrl = ALU_SUB;
        branch   = 1'b1;
      end
      OP_J: begin
        jump = 1'b1;
      end
      OP_JAL: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        dest      = 5'd31;
      end
      default: illegal = 1'b1;
    endcase

    // An illegal encoding must look like a no-op downstream apart from the illegal flag.
    if (illegal) begin
      alu_ctrl    = ALU_AND;
      dest        = 5'd0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_imm = 1'b0;
      branch      = 1'b0;
      jump        = 1'b0;
    end
  end

  logic [31:0]  ctrl;
  logic [191:0] id_ex_d;
  logic [191:0] id_ex_q;

  assign ctrl = {rs, rt, rd, dest, alu_ctrl, reg_write, mem_read, mem_write,
                 mem_to_reg, alu_src_imm, branch, jump, illegal};

  assign id_ex_d = {pc, ins, imm, br_tgt, j_tgt, ctrl};

  // ID/EX register boundary
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign ID_EX = id_ex_q;

endmodule

// File: tb/tb_id_decoder.sv
// Bench for id_decoder: directed vectors with fixed expectations, reset behaviour,
// and randomized words checked against a table-driven reference model.
module tb_id_decoder;

  logic         clock;
  logic         reset;
  logic [63:0]  IF_ID;
  logic [191:0] ID_EX;

  int checks = 0;
  int errors = 0;

  int op_alu[int];
  int op_flags[int];
  int fn_alu[int];

  id_decoder dut (
    .clock(clock),
    .reset(reset),
    .IF_ID(IF_ID),
    .ID_EX(ID_EX)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] ref_model(input logic [63:0] w);
    longint pc, ins, op, fn, rs, rt, rd, s, imm, br, jt, ctrl;
    longint alu, flags, dest;
    bit legal;
    pc  = longint'(w[63:32]);
    ins = longint'(w[31:0]);
    op  = ins / (2**26);
    fn  = ins % 64;
    rs  = (ins / (2**21)) % 32;
    rt  = (ins / (2**16)) % 32;
    rd  = (ins / (2**11)) % 32;
    s   = ins % 65536;
    if (s >= 32768) s = s - 65536;
    if (op == 12 || op == 13) imm = ins % 65536;
    else imm = (s + 2**32) % 2**32;
    br = (pc + s * 4 + 2**34) % 2**32;
    jt = (pc / 2**28) * 2**28 + (ins % 2**26) * 4;
    if (op == 0) legal = fn_alu.exists(int'(fn));
    else legal = op_alu.exists(int'(op));
    alu = 0; flags = 0; dest = 0;
    if (legal) begin
      alu   = (op == 0) ? fn_alu[int'(fn)] : op_alu[int'(op)];
      flags = (op == 0) ? 128 : op_flags[int'(op)];
      if (flags >= 128) dest = (op == 0) ? rd : (op == 3) ? 31 : rt;
    end
    ctrl = rs * 2**27 + rt * 2**22 + rd * 2**17 + dest * 2**12 + alu * 256 + flags
         + (legal ? 0 : 1);
    ref_model = {pc[31:0], ins[31:0], imm[31:0], br[31:0], jt[31:0], ctrl[31:0]};
  endfunction

  task automatic step(input logic [63:0] w);
    @(negedge clock);
    IF_ID = w;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [191:0] exp_w;
    logic [191:0] held;
    logic [31:0]  ins;
    int           legal_ops[10];
    int           legal_fns[7];

    op_alu[8]  = 2; op_flags[8]  = 8'h88;
    op_alu[12] = 0; op_flags[12] = 8'h88;
    op_alu[13] = 1; op_flags[13] = 8'h88;
    op_alu[10] = 7; op_flags[10] = 8'h88;
    op_alu[35] = 2; op_flags[35] = 8'hD8;
    op_alu[43] = 2; op_flags[43] = 8'h28;
    op_alu[4]  = 6; op_flags[4]  = 8'h04;
    op_alu[2]  = 0; op_flags[2]  = 8'h02;
    op_alu[3]  = 0; op_flags[3]  = 8'h82;
    fn_alu[32] = 2; fn_alu[34] = 6; fn_alu[36] = 0; fn_alu[37] = 1;
    fn_alu[39] = 12; fn_alu[42] = 7; fn_alu[0] = 3;
    legal_ops = '{0, 2, 3, 4, 8, 10, 12, 13, 35, 43};
    legal_fns = '{0, 32, 34, 36, 37, 39, 42};

    reset = 1'b0;
    IF_ID = 64'h0123_4567_89AB_CDEF;
    #1 reset = 1'b1;
    #1 check("reset_async", ID_EX, 192'h0);
    @(posedge clock); #1;
    check("reset_held", ID_EX, 192'h0);
    @(negedge clock);
    reset = 1'b0;

    step(64'hFFFF0000_FFFF0000);
    check("illegal_op", ID_EX,
          {32'hFFFF0000, 32'hFFFF0000, 32'h00000000, 32'hFFFF0000, 32'hFFFC0000, 32'hFFC00001});

    step(64'h00000004_00221820);
    check("add_imm", ID_EX[127:96], 192'(32'h00001820));
    check("add_br", ID_EX[95:64], 192'(32'h00006084));
    check("add_ctrl", ID_EX[31:0], 192'(32'h08863280));

    step(64'h00000100_8CC5FFFC);
    check("lw_imm", ID_EX[127:96], 192'(32'hFFFFFFFC));
    check("lw_br", ID_EX[95:64], 192'(32'h000000F0));
    check("lw_ctrl", ID_EX[31:0], 192'(32'h317E52D8));

    step(64'h00000000_3402FFFF);
    check("ori_imm", ID_EX[127:96], 192'(32'h0000FFFF));
    check("ori_dest", ID_EX[16:12], 192'(5'd2));
    check("ori_alu", ID_EX[11:8], 192'(4'd1));
    check("ori_flags", ID_EX[7:0], 192'(8'h88));

    step(64'hA0000008_0C000040);
    check("jal_tgt", ID_EX[63:32], 192'(32'hA0000100));
    check("jal_dest", ID_EX[16:12], 192'(5'd31));
    check("jal_flags", ID_EX[7:0], 192'(8'h82));

    // Input change between edges must not disturb the captured word.
    held = ID_EX;
    @(negedge clock);
    IF_ID = 64'h12345678_00000000;
    #2 check("hold_between_edges", ID_EX, held);

    // Reset mid-stream.
    step(64'h00000004_00221820);
    check("pre_reset_nonzero", 192'(ID_EX != 192'h0), 192'(1));
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check("midreset_async", ID_EX, 192'h0);
    repeat (2) begin
      @(posedge clock); #1;
      check("midreset_held", ID_EX, 192'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    step(64'h00000100_8CC5FFFC);
    check("post_reset_capture", ID_EX, ref_model(64'h00000100_8CC5FFFC));

    for (int i = 0; i < 300; i++) begin
      logic [63:0] w;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0)
        ins[31:26] = 6'(legal_ops[$urandom_range(0, 9)]);
      if (ins[31:26] == 6'd0 && $urandom_range(0, 3) != 0)
        ins[5:0] = 6'(legal_fns[$urandom_range(0, 6)]);
      w = {32'($urandom), ins};
      exp_w = ref_model(w);
      step(w);
      check("random", ID_EX, exp_w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
